// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - access-size/state enums and lane helpers for the DMEM arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_RSV = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE = 2'b00, RMW_WR = 2'b01, RESP = 2'b10} state_e;

  // Byte offset of the addressed lane after forcing the offset to the size alignment.
  function automatic logic [1:0] lane_base(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one request/response port of the DMEM arbiter
interface dmem_arbiter_if #(
  parameter int N    = 32,
  parameter int ADDR = 11
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic [ADDR+1:0] req_addr;
  logic [N-1:0]    req_wdata;
  logic            rsp_valid;
  logic [N-1:0]    rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_merge.sv
// rtl/dmem_lane_merge.sv - byte-lane load extract and store merge for 32-bit DMEM words
module dmem_lane_merge
  import dmem_arb_pkg::*;
(
  input  logic [31:0] ld_word,
  input  size_e       ld_size,
  input  logic [1:0]  ld_off,
  output logic [31:0] ld_data,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_e       st_size,
  input  logic [1:0]  st_off,
  output logic [31:0] merged
);
  logic [31:0] ld_shift;
  logic [31:0] st_shift;
  logic [3:0]  mask;

  assign ld_shift = ld_word >> {lane_base(ld_size, ld_off), 3'b000};
  assign st_shift = wdata << {lane_base(st_size, st_off), 3'b000};
  assign mask     = byte_mask(st_size, st_off);

  always_comb begin
    ld_data = '0;
    case (ld_size)
      SZ_B:    ld_data[7:0]  = ld_shift[7:0];
      SZ_H:    ld_data[15:0] = ld_shift[15:0];
      default: ld_data       = ld_word;
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = st_shift[8*i +: 8];
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port DMEM arbiter with sub-word read-modify-write
// Optional: DMEM_ARB_MISALIGN_EN reports misaligned/reserved-size requests as errors instead of masking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N    = 32,
  parameter int ADDR = 11
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_arbiter_if.slave   p0,
  dmem_arbiter_if.slave   p1,
  output logic [ADDR-1:0] dmem_addr_o,
  output logic [N-1:0]    dmem_st_data_o,
  output logic            dmem_st_en_o,
  input  logic [N-1:0]    dmem_ld_data_i
);
  state_e          state_q, state_d;
  logic            last_grant_q, rsp_port_q;
  logic [N-1:0]    rdata_q;
  logic [N-1:0]    rmw_old_q, rmw_wdata_q;
  logic [ADDR-1:0] rmw_addr_q;
  size_e           rmw_size_q;
  logic [1:0]      rmw_off_q;

  logic            gnt, accept, misalign, sub_word, rsp0_valid, rsp1_valid;
  logic            sel_we;
  size_e           sel_size;
  logic [ADDR+1:0] sel_addr;
  logic [N-1:0]    sel_wdata, ld_lane, merged;

  // On contention the port that did not win last time is served.
  assign gnt    = (p0.req_valid & p1.req_valid) ? ~last_grant_q : p1.req_valid;
  assign accept = (state_q == IDLE) & (p0.req_valid | p1.req_valid) & ~rst_i;

  assign p0.req_ready = accept & ~gnt;
  assign p1.req_ready = accept & gnt;

  assign sel_we    = gnt ? p1.req_we    : p0.req_we;
  assign sel_size  = size_e'(gnt ? p1.req_size : p0.req_size);
  assign sel_addr  = gnt ? p1.req_addr  : p0.req_addr;
  assign sel_wdata = gnt ? p1.req_wdata : p0.req_wdata;
  assign sub_word  = (sel_size == SZ_B) | (sel_size == SZ_H);

  dmem_lane_merge u_lane (
    .ld_word  (dmem_ld_data_i),
    .ld_size  (sel_size),
    .ld_off   (sel_addr[1:0]),
    .ld_data  (ld_lane),
    .old_word (rmw_old_q),
    .wdata    (rmw_wdata_q),
    .st_size  (rmw_size_q),
    .st_off   (rmw_off_q),
    .merged   (merged)
  );

  always_comb begin
    state_d        = state_q;
    dmem_addr_o    = sel_addr[ADDR+1:2];
    dmem_st_data_o = sel_wdata;
    dmem_st_en_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (misalign) begin
            state_d = RESP;
          end else if (sel_we && sub_word) begin
            state_d = RMW_WR;
          end else begin
            state_d      = RESP;
            dmem_st_en_o = sel_we;
          end
        end
      end
      RMW_WR: begin
        dmem_addr_o    = rmw_addr_q;
        dmem_st_data_o = merged;
        dmem_st_en_o   = ~rst_i;
        state_d        = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_port_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= gnt;
        rsp_port_q   <= gnt;
        rdata_q      <= (sel_we | misalign) ? '0 : ld_lane;
      end
    end
  end

  // The old word is captured at accept so the merge happens without a second read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rmw_old_q   <= dmem_ld_data_i;
      rmw_wdata_q <= sel_wdata;
      rmw_addr_q  <= sel_addr[ADDR+1:2];
      rmw_size_q  <= sel_size;
      rmw_off_q   <= sel_addr[1:0];
    end
  end

  assign rsp0_valid   = (state_q == RESP) & ~rst_i & ~rsp_port_q;
  assign rsp1_valid   = (state_q == RESP) & ~rst_i & rsp_port_q;
  assign p0.rsp_valid = rsp0_valid;
  assign p1.rsp_valid = rsp1_valid;
  assign p0.rsp_rdata = rdata_q;
  assign p1.rsp_rdata = rdata_q;

`ifdef DMEM_ARB_MISALIGN_EN
  logic err_q;
  assign misalign = is_misaligned(sel_size, sel_addr[1:0]);
  always_ff @(posedge clk_i) begin
    if (rst_i)       err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end
  assign p0.rsp_err = rsp0_valid & err_q;
  assign p1.rsp_err = rsp1_valid & err_q;
`else
  assign misalign   = 1'b0;
  assign p0.rsp_err = 1'b0;
  assign p1.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a byte-level memory reference model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.N(32), .ADDR(11)) port0 ();
  dmem_arbiter_if #(.N(32), .ADDR(11)) port1 ();

  logic [10:0] dmem_addr;
  logic [31:0] dmem_st_data, dmem_ld_data;
  logic        dmem_st_en;

  dmem_arbiter #(.N(32), .ADDR(11)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .p0             (port0),
    .p1             (port1),
    .dmem_addr_o    (dmem_addr),
    .dmem_st_data_o (dmem_st_data),
    .dmem_st_en_o   (dmem_st_en),
    .dmem_ld_data_i (dmem_ld_data)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic [31:0] mem [2048];
  logic [31:0] ref_mem [2048];
  bit          mem_ready = 1'b0;
  exp_t        sbq [2][$];
  int          glog [$];
  int          acc_cnt [2];
  int          st_cnt [2];
  int          edges = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          pend = 1'b0;
  int          pend_w;
  logic [31:0] pend_v;

  function automatic logic [31:0] init_word(int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // DMEM: combinational read, clocked write.
  assign dmem_ld_data = mem[dmem_addr];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (dmem_st_en) begin
      mem[dmem_addr] <= dmem_st_data;
    end
  end

  // Reference: each accepted request is applied to a byte-addressed view of memory.
  function automatic void model_accept(int p, logic we, logic [1:0] sz, logic [12:0] a, logic [31:0] wd);
    exp_t e;
    int nb, off, base, w;
    logic bad;
    logic [31:0] nv;
    w    = int'(a[12:2]);
    off  = int'(a[1:0]);
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = off - (off % nb);
`ifdef DMEM_ARB_MISALIGN_EN
    bad = (sz == 2'b11) || (off % nb != 0);
`else
    bad = 1'b0;
`endif
    e.rdata = '0;
    e.err   = bad;
    e.due   = edges;
    acc_cnt[p]++;
    glog.push_back(p);
    if (!bad) begin
      if (!we) begin
        e.rdata = 32'((64'(ref_mem[w]) >> (8 * base)) & ((64'd1 << (8 * nb)) - 64'd1));
      end else begin
        nv = ref_mem[w];
        for (int i = 0; i < nb; i++) nv[8*(base+i) +: 8] = wd[8*i +: 8];
        if (nb == 4) begin
          ref_mem[w] = nv;
        end else begin
          pend   = 1'b1;
          pend_w = w;
          pend_v = nv;
          e.due  = edges + 1;
        end
      end
    end
    sbq[p].push_back(e);
  endfunction

  always @(posedge clk) begin
    logic a0, a1;
    edges++;
    if (edges == 1) for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    a0 = port0.req_valid & port0.req_ready;
    a1 = port1.req_valid & port1.req_ready;
    if (rst) begin
      sbq[0].delete();
      sbq[1].delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        ref_mem[pend_w] = pend_v;
        pend = 1'b0;
      end
      if (a0 | a1) chk("single_grant", 32'(a0 & a1), 32'd0);
      if (a0) model_accept(0, port0.req_we, port0.req_size, port0.req_addr, port0.req_wdata);
      if (a1) model_accept(1, port1.req_we, port1.req_size, port1.req_addr, port1.req_wdata);
    end
  end

  function automatic void mon(int p, logic v, logic [31:0] rd, logic er);
    exp_t e;
    if (v) begin
      if (sbq[p].size() == 0) begin
        chk($sformatf("rsp%0d_unexpected", p), 32'(sbq[p].size()), 32'd1);
      end else begin
        e = sbq[p].pop_front();
        chk($sformatf("rsp%0d_rdata", p), rd, e.rdata);
        chk($sformatf("rsp%0d_err", p), 32'(er), 32'(e.err));
        chk($sformatf("rsp%0d_latency", p), 32'(edges), 32'(e.due));
      end
    end else if (sbq[p].size() != 0 && sbq[p][0].due <= edges) begin
      chk($sformatf("rsp%0d_missing", p), 32'(v), 32'd1);
      e = sbq[p].pop_front();
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", 32'({port0.req_ready, port1.req_ready, port0.rsp_valid,
                                port1.rsp_valid, dmem_st_en}), 32'd0);
    end else begin
      mon(0, port0.rsp_valid, port0.rsp_rdata, port0.rsp_err);
      mon(1, port1.rsp_valid, port1.rsp_rdata, port1.rsp_err);
    end
  end

  task automatic set_req(input int p, input logic we, input logic [1:0] sz,
                         input logic [12:0] a, input logic [31:0] wd);
    st_cnt[p] = acc_cnt[p];
    if (p == 0) begin
      port0.req_valid = 1'b1; port0.req_we = we; port0.req_size = sz;
      port0.req_addr  = a;    port0.req_wdata = wd;
    end else begin
      port1.req_valid = 1'b1; port1.req_we = we; port1.req_size = sz;
      port1.req_addr  = a;    port1.req_wdata = wd;
    end
  endtask

  task automatic wait_acc(input int p);
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (acc_cnt[p] == st_cnt[p] && t < 40);
    chk($sformatf("accept_p%0d", p), 32'(acc_cnt[p]), 32'(st_cnt[p] + 1));
    if (p == 0) port0.req_valid = 1'b0;
    else        port1.req_valid = 1'b0;
  endtask

  task automatic issue(input int p, input logic we, input logic [1:0] sz,
                       input logic [12:0] a, input logic [31:0] wd);
    set_req(p, we, sz, a, wd);
    wait_acc(p);
  endtask

  task automatic rand_traffic(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      issue(p, 1'($urandom), 2'($urandom), 13'h100 + 13'($urandom_range(0, 31)), $urandom);
    end
  endtask

  initial begin
    int start;
    port0.req_valid = 1'b0; port0.req_we = 1'b0; port0.req_size = 2'b10;
    port0.req_addr  = '0;   port0.req_wdata = '0;
    port1.req_valid = 1'b0; port1.req_we = 1'b0; port1.req_size = 2'b10;
    port1.req_addr  = '0;   port1.req_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Word store then load back.
    set_req(0, 1'b1, 2'b10, 13'h010, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_st_en", 32'(dmem_st_en), 32'd1);
    chk("t2_st_data", dmem_st_data, 32'hDEADBEEF);
    chk("t2_addr", 32'(dmem_addr), 32'd4);
    wait_acc(0);
    issue(0, 1'b0, 2'b10, 13'h010, 32'h0);

    // Byte store over a known word: write lands one cycle after accept.
    issue(0, 1'b1, 2'b10, 13'h010, 32'h11223344);
    set_req(0, 1'b1, 2'b00, 13'h013, 32'h000000AA);
    @(negedge clk);
    chk("t3_no_st_at_accept", 32'(dmem_st_en), 32'd0);
    wait_acc(0);
    @(negedge clk);
    chk("t3_rmw_st_en", 32'(dmem_st_en), 32'd1);
    chk("t3_rmw_data", dmem_st_data, 32'hAA223344);
    chk("t3_rmw_addr", 32'(dmem_addr), 32'd4);
    issue(0, 1'b0, 2'b10, 13'h010, 32'h0);
    issue(0, 1'b0, 2'b01, 13'h012, 32'h0);
    issue(1, 1'b0, 2'b00, 13'h011, 32'h0);

    // Both ports continuously valid: grants must alternate starting with port 0.
    start = glog.size();
    fork
      begin
        issue(0, 1'b1, 2'b10, 13'h040, 32'hCAFE0001);
        issue(0, 1'b1, 2'b10, 13'h044, 32'hCAFE0002);
      end
      begin
        issue(1, 1'b0, 2'b10, 13'h010, 32'h0);
        issue(1, 1'b0, 2'b10, 13'h040, 32'h0);
      end
    join
    for (int i = 0; i < 4; i++) chk($sformatf("t5_grant%0d", i), 32'(glog[start+i]), 32'(i % 2));

    // Reset during the read-modify-write cycle drops the write and its response.
    issue(0, 1'b1, 2'b10, 13'h020, 32'h55667788);
    set_req(0, 1'b1, 2'b00, 13'h021, 32'h00000099);
    wait_acc(0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_st_en_in_reset", 32'(dmem_st_en), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_mem_unchanged", mem[8], 32'h55667788);
    issue(0, 1'b0, 2'b10, 13'h020, 32'h0);

`ifdef DMEM_ARB_MISALIGN_EN
    issue(0, 1'b0, 2'b10, 13'h002, 32'h0);
    issue(1, 1'b1, 2'b01, 13'h021, 32'h1234);
`endif

    fork
      rand_traffic(0, 60);
      rand_traffic(1, 60);
    join
    repeat (6) @(posedge clk);
    #1;
    chk("drain", 32'(sbq[0].size() + sbq[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
